// File: rtl/cmsdk_apb_wdog_rstctrl.sv
// Watchdog reset-request controller: stretched SYSRESETREQ with hold-off, NMI, cause flags, event count.
// Optional LOCKUP source enabled by defining ARM_CMSDK_RSTCTRL_LOCKUP_EN.
module cmsdk_apb_wdog_rstctrl #(
    parameter int PULSE_DEFAULT = 16,
    parameter int HOLDOFF       = 32,
    parameter int COUNT_W       = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [11:2] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    input  logic        WDOGINT,
    input  logic        WDOGRES,
    input  logic        LOCKUP,
    output logic        SYSRESETREQ,
    output logic        WDOGNMI
);

`ifdef ARM_CMSDK_RSTCTRL_LOCKUP_EN
    localparam logic LK_EN = 1'b1;
`else
    localparam logic LK_EN = 1'b0;
`endif

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ASSERT = 2'd1;
    localparam logic [1:0]  S_HOLD   = 2'd2;
    localparam logic [15:0] HOLD_LD  = 16'(HOLDOFF - 1);
    localparam logic [31:0] SW_KEY   = 32'h05FA_0001;

    logic               wr;
    logic               rd;
    logic               a_ctrl;
    logic               a_pulse;
    logic               a_cause;
    logic               a_count;
    logic               a_swrst;
    logic [2:0]         ctrl_q;
    logic [7:0]         pulse_q;
    logic [7:0]         pulse_eff;
    logic [2:0]         cause_q;
    logic [2:0]         cause_set;
    logic [2:0]         cause_clr;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_nxt;
    logic [1:0]         state_q;
    logic [1:0]         state_nxt;
    logic [15:0]        cnt_q;
    logic [15:0]        cnt_nxt;
    logic               wdogres_q;
    logic               lockup_q;
    logic               lockup_lvl;
    logic               wdog_rise;
    logic               lock_rise;
    logic               sw_req;
    logic               trig;
    logic               inc;
    logic [31:0]        rdata;

    assign wr      = PSEL & PWRITE & ~PENABLE;
    assign rd      = PSEL & ~PWRITE & ~PENABLE;
    assign a_ctrl  = (PADDR == 10'h000);
    assign a_pulse = (PADDR == 10'h001);
    assign a_cause = (PADDR == 10'h002);
    assign a_count = (PADDR == 10'h003);
    assign a_swrst = (PADDR == 10'h004);

    // Without the feature the lockup level is forced low so it never blocks hold-off exit.
    assign lockup_lvl = LOCKUP & LK_EN;
    assign wdog_rise  = WDOGRES & ~wdogres_q & ctrl_q[0];
    assign lock_rise  = lockup_lvl & ~lockup_q & ctrl_q[2];
    assign sw_req     = wr & a_swrst & (PWDATA == SW_KEY);
    assign trig       = wdog_rise | lock_rise | sw_req;

    assign pulse_eff = (pulse_q == 8'd0) ? 8'd1 : pulse_q;
    assign cause_set = {sw_req, lock_rise, wdog_rise};
    assign cause_clr = (wr & a_cause) ? PWDATA[2:0] : 3'b000;
    assign inc       = (state_q == S_IDLE) & trig;

    always_comb begin
        count_nxt = count_q;
        if (wr & a_count)
            count_nxt = inc ? COUNT_W'(1) : '0;
        else if (inc & ~(&count_q))
            count_nxt = count_q + COUNT_W'(1);
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_nxt = S_ASSERT;
                    cnt_nxt   = {8'd0, pulse_eff} - 16'd1;
                end
            end
            S_ASSERT: begin
                if (cnt_q == 16'd0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt_q - 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q != 16'd0)
                    cnt_nxt = cnt_q - 16'd1;
                else if (!WDOGRES && !lockup_lvl)
                    state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        if (a_ctrl)
            rdata[2:0] = ctrl_q;
        else if (a_pulse)
            rdata[7:0] = pulse_q;
        else if (a_cause)
            rdata[2:0] = cause_q;
        else if (a_count)
            rdata[COUNT_W-1:0] = count_q;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q      <= 3'b001;
            pulse_q     <= 8'(PULSE_DEFAULT);
            cause_q     <= 3'b000;
            count_q     <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            wdogres_q   <= 1'b0;
            lockup_q    <= 1'b0;
            PRDATA      <= 32'd0;
            SYSRESETREQ <= 1'b0;
            WDOGNMI     <= 1'b0;
        end else begin
            if (wr & a_ctrl)
                ctrl_q <= PWDATA[2:0] & {LK_EN, 2'b11};
            if (wr & a_pulse)
                pulse_q <= PWDATA[7:0];
            // Set beats a simultaneous W1C clear.
            cause_q     <= ((cause_q & ~cause_clr) | cause_set) & {1'b1, LK_EN, 1'b1};
            count_q     <= count_nxt;
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            wdogres_q   <= WDOGRES;
            lockup_q    <= lockup_lvl;
            PRDATA      <= rd ? rdata : 32'd0;
            SYSRESETREQ <= (state_nxt == S_ASSERT);
            WDOGNMI     <= WDOGINT & ctrl_q[1];
        end
    end

endmodule

// File: tb/tb_cmsdk_apb_wdog_rstctrl.sv
// Directed self-checking bench for cmsdk_apb_wdog_rstctrl (COUNT_W = 2 to reach saturation quickly).
module tb_cmsdk_apb_wdog_rstctrl;

    logic        clk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:2] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        wdogint;
    logic        wdogres;
    logic        lockup;
    logic        sysresetreq;
    logic        wdognmi;

    int n_checks = 0;
    int n_err    = 0;
    int hi_cnt   = 0;
    int h0;
    logic [31:0] rv;

`ifdef ARM_CMSDK_RSTCTRL_LOCKUP_EN
    localparam logic [31:0] CTRL5_RD  = 32'h5;
    localparam logic [31:0] CAUSE_ALL = 32'h7;
`else
    localparam logic [31:0] CTRL5_RD  = 32'h1;
    localparam logic [31:0] CAUSE_ALL = 32'h5;
`endif

    cmsdk_apb_wdog_rstctrl #(
        .PULSE_DEFAULT(16),
        .HOLDOFF(32),
        .COUNT_W(2)
    ) dut (
        .PCLK(clk),
        .PRESET(preset),
        .PSEL(psel),
        .PENABLE(penable),
        .PWRITE(pwrite),
        .PADDR(paddr),
        .PWDATA(pwdata),
        .PRDATA(prdata),
        .WDOGINT(wdogint),
        .WDOGRES(wdogres),
        .LOCKUP(lockup),
        .SYSRESETREQ(sysresetreq),
        .WDOGNMI(wdognmi)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (sysresetreq === 1'b1)
            hi_cnt <= hi_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        psel    = 1'b1;
        pwrite  = 1'b1;
        penable = 1'b0;
        paddr   = a[11:2];
        pwdata  = d;
        tick();
        penable = 1'b1;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
        psel    = 1'b1;
        pwrite  = 1'b0;
        penable = 1'b0;
        paddr   = a[11:2];
        tick();
        d       = prdata;
        penable = 1'b1;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        preset  = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        wdogint = 1'b0;
        wdogres = 1'b0;
        lockup  = 1'b0;
        repeat (3) tick();
        preset = 1'b0;
        tick();

        // reset state
        chk("rst_sysreq", {31'd0, sysresetreq}, 32'd0);
        chk("rst_nmi", {31'd0, wdognmi}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        apb_rd(12'h000, rv); chk("rst_ctrl", rv, 32'h1);
        apb_rd(12'h004, rv); chk("rst_pulse", rv, 32'h10);
        apb_rd(12'h008, rv); chk("rst_cause", rv, 32'h0);
        apb_rd(12'h00C, rv); chk("rst_count", rv, 32'h0);

        // watchdog reset: 16-cycle pulse starting one cycle after the edge
        wdogres = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            wdogres = 1'b0;
            chk($sformatf("wdog_pulse_%0d", i), {31'd0, sysresetreq},
                (i < 16) ? 32'd1 : 32'd0);
        end
        repeat (8) tick();
        wdogres = 1'b1;
        tick();
        wdogres = 1'b0;
        h0 = hi_cnt;
        repeat (4) tick();
        chk("holdoff_no_pulse", hi_cnt - h0, 32'd0);
        apb_rd(12'h008, rv); chk("wdog_cause", rv, 32'h1);
        apb_rd(12'h00C, rv); chk("wdog_count", rv, 32'h1);
        repeat (45) tick();

        // software reset with PULSE=0 behaves as a 1-cycle pulse
        apb_wr(12'h008, 32'h7);
        apb_wr(12'h004, 32'h0);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
        paddr = 10'h004; pwdata = 32'h05FA_0001;
        tick();
        chk("sw_pulse_on", {31'd0, sysresetreq}, 32'd1);
        penable = 1'b1;
        tick();
        chk("sw_pulse_off", {31'd0, sysresetreq}, 32'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb_rd(12'h008, rv); chk("sw_cause", rv, 32'h4);
        apb_rd(12'h00C, rv); chk("sw_count", rv, 32'h2);
        repeat (45) tick();
        h0 = hi_cnt;
        apb_wr(12'h010, 32'h05FA_0002);
        repeat (3) tick();
        chk("sw_badkey", hi_cnt - h0, 32'd0);
        apb_rd(12'h00C, rv); chk("sw_badkey_count", rv, 32'h2);
        apb_rd(12'h010, rv); chk("swrst_read", rv, 32'h0);

        // simultaneous sources: one pulse, one count
        apb_wr(12'h000, 32'h5);
        apb_rd(12'h000, rv); chk("ctrl5", rv, CTRL5_RD);
        apb_wr(12'h008, 32'h7);
        apb_wr(12'h004, 32'h4);
        h0 = hi_cnt;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
        paddr = 10'h004; pwdata = 32'h05FA_0001;
        wdogres = 1'b1; lockup = 1'b1;
        tick();
        wdogres = 1'b0; lockup = 1'b0; penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (8) tick();
        chk("multi_pulse_len", hi_cnt - h0, 32'd4);
        apb_rd(12'h00C, rv); chk("multi_count", rv, 32'h3);
        apb_rd(12'h008, rv); chk("multi_cause", rv, CAUSE_ALL);
        apb_wr(12'h008, 32'h2);
        apb_rd(12'h008, rv); chk("w1c_cause", rv, 32'h5);
        repeat (45) tick();

        // NMI gating and reset disable
        wdogint = 1'b1;
        tick();
        wdogint = 1'b0;
        chk("nmi_off", {31'd0, wdognmi}, 32'd0);
        apb_wr(12'h000, 32'h2);
        h0 = hi_cnt;
        wdogint = 1'b1; wdogres = 1'b1;
        tick();
        chk("nmi_on", {31'd0, wdognmi}, 32'd1);
        wdogint = 1'b0; wdogres = 1'b0;
        tick();
        chk("nmi_follow", {31'd0, wdognmi}, 32'd0);
        repeat (3) tick();
        chk("resen_off", hi_cnt - h0, 32'd0);

        // saturation and clear/increment collision
        apb_wr(12'h000, 32'h1);
        wdogres = 1'b1;
        tick();
        wdogres = 1'b0;
        apb_rd(12'h00C, rv); chk("count_sat", rv, 32'h3);
        repeat (45) tick();
        apb_wr(12'h00C, 32'h0);
        apb_rd(12'h00C, rv); chk("count_clr", rv, 32'h0);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
        paddr = 10'h003; pwdata = 32'h0;
        wdogres = 1'b1;
        tick();
        wdogres = 1'b0; penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb_rd(12'h00C, rv); chk("count_clr_inc", rv, 32'h1);
        repeat (45) tick();

        // PULSE write mid-pulse does not change current pulse
        h0 = hi_cnt;
        wdogres = 1'b1;
        tick();
        wdogres = 1'b0;
        apb_wr(12'h004, 32'h2);
        repeat (8) tick();
        chk("pulse_midwrite", hi_cnt - h0, 32'd4);
        apb_rd(12'h004, rv); chk("pulse_rd", rv, 32'h2);
        repeat (45) tick();

        // PRESET mid-pulse
        wdogres = 1'b1;
        tick();
        wdogres = 1'b0;
        tick();
        chk("pre_preset", {31'd0, sysresetreq}, 32'd1);
        preset = 1'b1;
        tick();
        chk("preset_mid", {31'd0, sysresetreq}, 32'd0);
        preset = 1'b0;
        tick();
        apb_rd(12'h004, rv); chk("preset_pulse", rv, 32'h10);
        apb_rd(12'h00C, rv); chk("preset_count", rv, 32'h0);
        wdogres = 1'b1;
        tick();
        wdogres = 1'b0;
        chk("preset_idle", {31'd0, sysresetreq}, 32'd1);
        repeat (60) tick();

        // unmapped offset
        apb_wr(12'h014, 32'hFFFF_FFFF);
        apb_rd(12'h014, rv); chk("unmapped", rv, 32'h0);
        apb_rd(12'h000, rv); chk("unmapped_ctrl", rv, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
